// File: rtl/philv_ctrl_exec.sv
// PhilosophyV multicycle RV32I control/execute slice: FSM, decoder, ALU.
// Optional LUI support is enabled by defining PHILV_LUI_EN.
module philv_ctrl_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] immed,
  output logic [3:0]      alu_funct,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero,
  output logic            pc_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic            reg_wr_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic            alu_override,
  output logic            illegal_instr,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EXE   = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5
  } state_t;

  localparam logic [3:0] F_ADD   = 4'd0;
  localparam logic [3:0] F_SUB   = 4'd1;
  localparam logic [3:0] F_SLL   = 4'd2;
  localparam logic [3:0] F_SLT   = 4'd3;
  localparam logic [3:0] F_SLTU  = 4'd4;
  localparam logic [3:0] F_XOR   = 4'd5;
  localparam logic [3:0] F_SRL   = 4'd6;
  localparam logic [3:0] F_SRA   = 4'd7;
  localparam logic [3:0] F_OR    = 4'd8;
  localparam logic [3:0] F_AND   = 4'd9;
  localparam logic [3:0] F_PASSB = 4'd10;

  state_t r_state;
  state_t w_next;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic            w_f7b;
  logic            w_is_r;
  logic            w_is_i;
  logic            w_is_lui;
  logic            w_legal;
  logic            w_sub;
  logic [3:0]      w_dec_f;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;

  assign w_opc    = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7b    = instr[30];
  assign w_is_r   = (w_opc == 7'b0110011);
  assign w_is_i   = (w_opc == 7'b0010011);
`ifdef PHILV_LUI_EN
  assign w_is_lui = (w_opc == 7'b0110111);
`else
  assign w_is_lui = 1'b0;
`endif
  assign w_legal  = w_is_r | w_is_i | w_is_lui;
  // SUB only exists in R-type; ADDI ignores bit 30.
  assign w_sub    = w_is_r & w_f7b;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rd_addr  = instr[11:7];
  assign state    = r_state;

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and Moore control outputs.
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_wr_src    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_override  = 1'b0;
    illegal_instr = 1'b0;
    unique case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        ir_write     = 1'b1;
        pc_write     = 1'b1;
        alu_override = 1'b1;
        alu_src_b    = 2'b01;
        w_next       = S_DEC;
      end
      S_DEC: begin
        alu_override  = 1'b1;
        alu_src_b     = 2'b10;
        illegal_instr = ~w_legal;
        w_next        = w_legal ? S_EXE : S_FETCH;
      end
      S_EXE, S_MEM, S_WB: begin
        alu_src_a = 1'b1;
        alu_src_b = w_is_r ? 2'b00 : 2'b10;
        if (r_state == S_WB) begin
          reg_write  = 1'b1;
          reg_wr_src = 1'b1;
          w_next     = S_FETCH;
        end else if (r_state == S_EXE) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Immediate generation; shift-immediates carry only the shamt.
  always_comb begin
    immed = '0;
    if (w_is_i) begin
      if (w_f3 == 3'b001 || w_f3 == 3'b101)
        immed = {27'b0, instr[24:20]};
      else
        immed = {{20{instr[31]}}, instr[31:20]};
    end else if (w_is_lui) begin
      immed = {instr[31:12], 12'b0};
    end
  end

  // Instruction-driven ALU function.
  always_comb begin
    w_dec_f = F_ADD;
    unique case (1'b1)
      w_is_r, w_is_i: begin
        unique case (w_f3)
          3'b000: w_dec_f = w_sub ? F_SUB : F_ADD;
          3'b001: w_dec_f = F_SLL;
          3'b010: w_dec_f = F_SLT;
          3'b011: w_dec_f = F_SLTU;
          3'b100: w_dec_f = F_XOR;
          3'b101: w_dec_f = w_f7b ? F_SRA : F_SRL;
          3'b110: w_dec_f = F_OR;
          default: w_dec_f = F_AND;
        endcase
      end
      w_is_lui: w_dec_f = F_PASSB;
      default:  w_dec_f = F_ADD;
    endcase
  end

  assign alu_funct = alu_override ? F_ADD : w_dec_f;

  // Operand muxes.
  always_comb begin
    w_a = alu_src_a ? rs1_data : pc;
    unique case (alu_src_b)
      2'b00:   w_b = rs2_data;
      2'b01:   w_b = 32'd4;
      2'b10:   w_b = immed;
      default: w_b = '0;
    endcase
  end

  // ALU; unused function codes give zero.
  always_comb begin
    unique case (alu_funct)
      F_ADD:   alu_result = w_a + w_b;
      F_SUB:   alu_result = w_a - w_b;
      F_SLL:   alu_result = w_a << w_b[4:0];
      F_SLT:   alu_result = {31'b0, $signed(w_a) < $signed(w_b)};
      F_SLTU:  alu_result = {31'b0, w_a < w_b};
      F_XOR:   alu_result = w_a ^ w_b;
      F_SRL:   alu_result = w_a >> w_b[4:0];
      F_SRA:   alu_result = $unsigned($signed(w_a) >>> w_b[4:0]);
      F_OR:    alu_result = w_a | w_b;
      F_AND:   alu_result = w_a & w_b;
      F_PASSB: alu_result = w_b;
      default: alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

endmodule

// File: tb/tb_philv_ctrl_exec.sv
// Self-checking bench for philv_ctrl_exec.
// Scoreboard of expected EXECUTE results; honours PHILV_LUI_EN.
module tb_philv_ctrl_exec;

  logic        clk;
  logic        rstb;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] immed, alu_result;
  logic [3:0]  alu_funct;
  logic        alu_zero, pc_write, ir_write, reg_write, reg_wr_src;
  logic        alu_src_a, alu_override, illegal_instr;
  logic [1:0]  alu_src_b;
  logic [2:0]  state;

  philv_ctrl_exec dut (
    .clk(clk), .rstb(rstb), .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .immed(immed), .alu_funct(alu_funct), .alu_result(alu_result),
    .alu_zero(alu_zero), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_wr_src(reg_wr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_override(alu_override), .illegal_instr(illegal_instr),
    .state(state)
  );

  typedef struct {
    bit          legal;
    logic [31:0] res;
    logic [31:0] imm;
    logic [1:0]  srcb;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: DECODE, EXECUTE and WRITEBACK checks.
  always @(negedge clk) begin
    if (rstb) begin
      if (state == 3'd2 && sb.size() > 0) begin
        check("illegal", {31'b0, illegal_instr}, {31'b0, !sb[0].legal});
        check("dec_srcb", {30'b0, alu_src_b}, 32'd2);
        if (!sb[0].legal) void'(sb.pop_front());
      end else if (state == 3'd3) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd0, 32'd1);
        end else begin
          cur = sb.pop_front();
          check("result", alu_result, cur.res);
          check("zero", {31'b0, alu_zero}, {31'b0, cur.res == 0});
          check("immed", immed, cur.imm);
          check("srcb", {30'b0, alu_src_b}, {30'b0, cur.srcb});
          check("src_a", {31'b0, alu_src_a}, 32'd1);
          check("exe_regw", {31'b0, reg_write}, 32'd0);
        end
      end else if (state == 3'd5) begin
        check("wb_regw", {31'b0, reg_write}, 32'd1);
        check("wb_src", {31'b0, reg_wr_src}, 32'd1);
        check("rd", {27'b0, rd_addr}, {27'b0, cur.rd});
      end
    end
  end

  // Issue one instruction from FETCH and time the return to FETCH.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input bit legal,
                       input logic [31:0] res, input logic [31:0] imm,
                       input logic [1:0] srcb, input logic [4:0] rd);
    exp_t e;
    int   cyc;
    e.legal = legal; e.res = res; e.imm = imm;
    e.srcb = srcb; e.rd = rd;
    instr = ins; rs1_data = a; rs2_data = b;
    sb.push_back(e);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (state != 3'd1 && cyc < 12);
    check("latency", cyc, legal ? 32'd5 : 32'd2);
  endtask

  initial begin
    rstb = 1'b0; instr = '0; pc = 32'h100;
    rs1_data = '0; rs2_data = '0;
    @(negedge clk);
    check("rst_state", {29'b0, state}, 32'd0);
    check("rst_en", {29'b0, ir_write, pc_write, reg_write}, 32'd0);
    rstb = 1'b1;
    @(negedge clk);
    check("fetch_state", {29'b0, state}, 32'd1);
    check("fetch_en", {30'b0, ir_write, pc_write}, 32'd3);
    check("fetch_pc4", alu_result, 32'h104);

    // ADD abandoned by a reset in EXECUTE.
    instr = 32'h002081B3; rs1_data = 7; rs2_data = 5;
    sb.push_back('{1'b1, 32'd12, 32'd0, 2'b00, 5'd3});
    @(negedge clk);
    @(negedge clk);
    check("mid_exe", {29'b0, state}, 32'd3);
    #2 rstb = 1'b0;
    #1;
    check("async_rst", {29'b0, state}, 32'd0);
    check("async_en", {29'b0, ir_write, pc_write, reg_write}, 32'd0);
    check("async_mux", {29'b0, alu_src_a, alu_src_b}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_hold", {28'b0, reg_write, state}, 32'd0);
    end
    rstb = 1'b1;
    #1;
    check("idle", {29'b0, state}, 32'd0);
    @(negedge clk);
    check("fetch2", {29'b0, state}, 32'd1);
    check("fetch2_pc4", alu_result, 32'h104);

    issue(32'h002081B3, 7, 5, 1, 32'd12, 0, 2'b00, 3);
    issue(32'h402081B3, 3, 5, 1, 32'hFFFFFFFE, 0, 2'b00, 3);
    issue(32'h402081B3, 5, 5, 1, 32'd0, 0, 2'b00, 3);
    issue(32'hFFF00093, 0, 9, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1);
    issue(32'h4010D093, 32'h80000000, 0, 1, 32'hC0000000, 1, 2'b10, 1);
    issue(32'h0020A1B3, 32'hFFFFFFFF, 1, 1, 32'd1, 0, 2'b00, 3);
    issue(32'h0020B1B3, 32'hFFFFFFFF, 1, 1, 32'd0, 0, 2'b00, 3);
    issue(32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 1,
          32'hFF00FF00, 0, 2'b00, 3);
    issue(32'h0020D1B3, 32'h80000000, 32'h24, 1,
          32'h08000000, 0, 2'b00, 3);
    issue(32'h4020D1B3, 32'h80000000, 32'h24, 1,
          32'hF8000000, 0, 2'b00, 3);
    issue(32'h0000007F, 1, 2, 0, 0, 0, 2'b00, 0);
`ifdef PHILV_LUI_EN
    issue(32'h123450B7, 0, 0, 1, 32'h12345000, 32'h12345000, 2'b10, 1);
`else
    issue(32'h123450B7, 0, 0, 0, 0, 0, 2'b00, 0);
`endif
    check("sb_drain", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
